// File: rtl/add_round_key_stage.sv
`default_nettype none
// ============================================================================
//  Module      : add_round_key_stage
//  Description : AES-128 AddRoundKey stage with on-the-fly key expansion and
//                a one-deep valid/ready output register.
//  Revision    : 1.0  initial release
// ============================================================================
module add_round_key_stage #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic [3:0]   round_out,
  output logic         last_round
);

  generate
    if (NR != 10) begin : g_nr_unsupported
      $error("add_round_key_stage supports only NR = 10");
    end
  endgenerate

  localparam logic [3:0] c_last = 4'(NR);

  localparam logic [0:255][7:0] c_sbox = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic         r_key_valid;
  logic [127:0] r_base_key;
  logic [127:0] r_rk;
  logic [7:0]   r_rcon;
  logic [3:0]   r_round;

  logic         w_accept;
  logic [31:0]  w_rot;
  logic [31:0]  w_temp;
  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [127:0] w_rk_next;
  logic [7:0]   w_rcon_next;

  assign in_ready = r_key_valid && !key_load && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // One key-expansion step: RotWord, SubWord, Rcon, then the chained word XORs.
  assign w_rot  = {r_rk[23:0], r_rk[31:24]};
  assign w_temp = {c_sbox[w_rot[31:24]] ^ r_rcon, c_sbox[w_rot[23:16]],
                   c_sbox[w_rot[15:8]], c_sbox[w_rot[7:0]]};
  assign w_w0   = r_rk[127:96] ^ w_temp;
  assign w_w1   = r_rk[95:64]  ^ w_w0;
  assign w_w2   = r_rk[63:32]  ^ w_w1;
  assign w_w3   = r_rk[31:0]   ^ w_w2;
  assign w_rk_next   = {w_w0, w_w1, w_w2, w_w3};
  assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_valid <= 1'b0;
      r_base_key  <= '0;
      r_rk        <= '0;
      r_rcon      <= 8'h01;
      r_round     <= '0;
      out_valid   <= 1'b0;
      data_out    <= '0;
      round_out   <= '0;
      last_round  <= 1'b0;
    end else if (key_load) begin
      r_base_key  <= key_in;
      r_rk        <= key_in;
      r_rcon      <= 8'h01;
      r_round     <= '0;
      r_key_valid <= 1'b1;
      out_valid   <= 1'b0;
    end else if (w_accept) begin
      data_out   <= data_in ^ r_rk;
      round_out  <= r_round;
      last_round <= (r_round == c_last);
      out_valid  <= 1'b1;
      // After the final round, rewind to the cipher key for the next block.
      if (r_round == c_last) begin
        r_rk    <= r_base_key;
        r_rcon  <= 8'h01;
        r_round <= '0;
      end else begin
        r_rk    <= w_rk_next;
        r_rcon  <= w_rcon_next;
        r_round <= r_round + 4'd1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_add_round_key_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add_round_key_stage
//  Description : Self-checking bench for add_round_key_stage against a
//                FIPS-197 style key-schedule and handshake model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_add_round_key_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_load;
  logic [127:0] key_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic [3:0]   round_out;
  logic         last_round;

  add_round_key_stage #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .round_out(round_out), .last_round(last_round)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox [256];
  logic [127:0] m_rks [11];
  logic         m_kv, m_ov, m_last;
  logic [127:0] m_data;
  int           m_rout, m_round;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box derived from the GF(2^8) inverse and the affine map.
  task automatic build_sbox();
    for (int b = 0; b < 256; b++) begin
      logic [7:0] inv = 0;
      for (int x = 1; x < 256; x++)
        if (b != 0 && gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      sbox[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) m_rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic model_reset();
    m_kv = 0; m_ov = 0; m_last = 0; m_data = 0; m_rout = 0; m_round = 0;
    for (int r = 0; r <= 10; r++) m_rks[r] = 0;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 128'(out_valid), 128'(m_ov));
    chk("data_out", data_out, m_data);
    chk("round_out", 128'(round_out), 128'(m_rout));
    chk("last_round", 128'(last_round), 128'(m_last));
  endtask

  // One clock: drive inputs, check in_ready, advance model, check registered outputs.
  task automatic cycle(input logic kl, input logic [127:0] kin, input logic iv,
                       input logic [127:0] din, input logic ordy);
    logic exp_ready;
    key_load = kl; key_in = kin; in_valid = iv; data_in = din; out_ready = ordy;
    #1;
    exp_ready = m_kv && !kl && (!m_ov || ordy);
    chk("in_ready", 128'(in_ready), 128'(exp_ready));
    if (kl) begin
      expand_key(kin);
      m_kv = 1; m_ov = 0; m_round = 0;
    end else if (iv && exp_ready) begin
      m_data = din ^ m_rks[m_round];
      m_rout = m_round;
      m_last = (m_round == 10);
      m_ov = 1;
      m_round = (m_round == 10) ? 0 : m_round + 1;
    end else if (m_ov && ordy) begin
      m_ov = 0;
    end
    @(posedge clk); #1;
    check_outputs();
  endtask

  logic [127:0] held;

  initial begin
    build_sbox();
    model_reset();
    rst_n = 0; key_load = 0; key_in = 0; in_valid = 0; data_in = 0; out_ready = 1;
    #1;
    check_outputs();
    chk("reset_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk); #1; rst_n = 1;

    // No key loaded: nothing may be accepted.
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 128'h1234, 1);

    // Known-answer round 0.
    cycle(1, KEY, 0, 0, 1);
    cycle(0, 0, 1, 128'h3243f6a8885a308d313198a2e0370734, 1);
    chk("kat_round0", data_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);

    // Reload and stream 12 zero states back-to-back.
    cycle(1, KEY, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 1, 0, 1);
      if (i == 1) chk("kat_round1", data_out, 128'ha0fafe1788542cb123a339392a6c7605);
      if (i == 10) begin
        chk("kat_round10", data_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("kat_last", 128'({round_out, last_round}), 128'({4'd10, 1'b1}));
      end
      if (i == 11) chk("kat_wrap", data_out, KEY);
    end

    // Random key, backpressure for 3 cycles after the first output.
    cycle(1, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1);
    cycle(0, 0, 1, {$urandom, $urandom, $urandom, $urandom}, 1);
    held = data_out;
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, {$urandom, $urandom, $urandom, $urandom}, 0);
    chk("held_data", data_out, held);
    for (int i = 0; i < 30; i++)
      cycle(0, 0, ($urandom % 4) != 0, {$urandom, $urandom, $urandom, $urandom}, ($urandom % 3) != 0);

    // Key load mid-message at round 5, with a simultaneous valid input.
    cycle(1, KEY, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, {$urandom, $urandom, $urandom, $urandom}, 1);
    cycle(1, 128'h000102030405060708090a0b0c0d0e0f, 1, 128'hdead, 1);
    cycle(0, 0, 1, 0, 1);
    chk("reload_key", data_out, 128'h000102030405060708090a0b0c0d0e0f);

    // Asynchronous reset between clock edges.
    cycle(0, 0, 1, {$urandom, $urandom, $urandom, $urandom}, 0);
    #2; rst_n = 0; #1;
    model_reset();
    check_outputs();
    chk("arst_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk); #1; rst_n = 1;
    cycle(0, 0, 1, 128'h55, 1);
    cycle(0, 0, 1, 128'h66, 1);
    cycle(1, KEY, 0, 0, 1);
    cycle(0, 0, 1, 128'h3243f6a8885a308d313198a2e0370734, 1);
    chk("kat_after_reset", data_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
